// File: rtl/cpu_pkg.sv
// Shared VeriRISC types: instruction opcodes, sequencer phases and the
// decode helper that classifies accumulator-loading instructions.
package cpu_pkg;

   typedef enum logic [2:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_t;

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_t;

   // Instructions that fetch an operand from memory into the accumulator.
   function automatic logic is_aluop(input opcode_t op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

endpackage

// File: rtl/controller.sv
// VeriRISC instruction sequencer: an 8-phase fetch/execute ring plus a halted
// flag, decoded combinationally into single-cycle datapath strobes.
module controller
   import cpu_pkg::*;
#(
   parameter int PHASES = 8
) (
   input  logic       clk,
   input  logic       rst_,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       mem_rd,
   output logic       load_ir,
   output logic       halt,
   output logic       inc_pc,
   output logic       load_ac,
   output logic       load_pc,
   output logic       mem_wr,
   output logic [2:0] phase
);

   phase_t  phase_q, phase_d;
   logic    halted_q, halted_d;
   opcode_t op;
   logic    aluop;

   assign op    = opcode_t'(opcode);
   assign aluop = is_aluop(op);
   assign phase = phase_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, independent of block ordering.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         phase_q  <= INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   // NOTE: every output of this block is given a default first, so no path
   // through the case statement can leave a signal unassigned and infer a latch.
   always_comb begin
      phase_d  = phase_q;
      halted_d = halted_q;
      mem_rd   = 1'b0;
      load_ir  = 1'b0;
      halt     = 1'b0;
      inc_pc   = 1'b0;
      load_ac  = 1'b0;
      load_pc  = 1'b0;
      mem_wr   = 1'b0;

      if (halted_q) begin
         // Frozen in OP_FETCH; only reset leaves this state.
         halt = 1'b1;
      end else begin
         phase_d = phase_t'(3'(phase_q + 3'd1));
         unique case (phase_q)
            INST_ADDR: ;
            INST_FETCH: mem_rd = 1'b1;
            INST_LOAD, IDLE: begin
               mem_rd  = 1'b1;
               load_ir = 1'b1;
            end
            OP_ADDR: begin
               inc_pc = 1'b1;
               if (op == HLT) begin
                  halt     = 1'b1;
                  halted_d = 1'b1;
               end
            end
            OP_FETCH: mem_rd = aluop;
            ALU_OP: begin
               mem_rd  = aluop;
               load_ac = aluop;
               inc_pc  = (op == SKZ) && zero;
               load_pc = (op == JMP);
            end
            STORE: begin
               mem_rd  = aluop;
               load_ac = aluop;
               // The PC gives load priority, so inc_pc alongside load_pc is harmless.
               inc_pc  = (op == JMP);
               load_pc = (op == JMP);
               mem_wr  = (op == STO);
            end
         endcase
      end
   end

   a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!rst_)
      !(mem_rd && mem_wr));

   a_load_ir_phase: assert property (@(posedge clk) disable iff (!rst_)
      load_ir |-> (phase_q == INST_LOAD || phase_q == IDLE));

   a_phase_known: assert property (@(posedge clk) disable iff (!rst_)
      !$isunknown(phase_q) && (int'(phase_q) < PHASES));

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for the VeriRISC controller: stimulus pushes hand-computed
// {phase, strobes} per cycle, a negedge monitor pops and compares.
module tb_controller;
   import cpu_pkg::*;

   // Strobe vector order: {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}
   typedef logic [6:0] strobe_t;
   typedef strobe_t    vec_t [8];

   typedef struct packed {
      logic [2:0] ph;
      strobe_t    st;
   } exp_t;

   localparam vec_t ALU_V  = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                               7'b0001000, 7'b1000000, 7'b1000100, 7'b1000100};
   localparam vec_t SKZ1_V = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                               7'b0001000, 7'b0000000, 7'b0001000, 7'b0000000};
   localparam vec_t SKZ0_V = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                               7'b0001000, 7'b0000000, 7'b0000000, 7'b0000000};
   localparam vec_t JMP_V  = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                               7'b0001000, 7'b0000000, 7'b0000010, 7'b0001010};
   localparam vec_t STO_V  = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                               7'b0001000, 7'b0000000, 7'b0000000, 7'b0000001};
   localparam vec_t HLT_V  = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                               7'b0011000, 7'b0010000, 7'b0010000, 7'b0010000};
   localparam strobe_t HALTED = 7'b0010000;

   logic       clk = 1'b0;
   logic       rst_ = 1'b0;
   logic [2:0] opcode = 3'd0;
   logic       zero = 1'b0;
   logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
   logic [2:0] phase;

   int   checks = 0;
   int   failures = 0;
   exp_t sb_q [$];

   controller #(.PHASES(8)) dut (
      .clk     (clk),
      .rst_    (rst_),
      .opcode  (opcode),
      .zero    (zero),
      .mem_rd  (mem_rd),
      .load_ir (load_ir),
      .halt    (halt),
      .inc_pc  (inc_pc),
      .load_ac (load_ac),
      .load_pc (load_pc),
      .mem_wr  (mem_wr),
      .phase   (phase)
   );

   always #5 clk = ~clk;

   function automatic strobe_t strobes();
      return {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};
   endfunction

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got phase=%0d strobes=%b, expected phase=%0d strobes=%b",
                  name, act[9:7], act[6:0], req[9:7], req[6:0]);
      end
   endtask

   // Monitor: every cycle with a pending expectation is compared at the falling edge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check($sformatf("cycle ph%0d", e.ph), {phase, strobes()}, {e.ph, e.st});
      end
   end

   // Drives phases 0..n-1 of one instruction; entered with the DUT in phase 0,
   // just after a rising edge. Phases 0-3 see a decoy opcode and zero.
   task automatic run_phases(input opcode_t op, input logic z, input vec_t exp, input int n);
      for (int ph = 0; ph < n; ph++) begin
         if (ph > 0) begin
            @(posedge clk);
            #1;
         end
         opcode = (ph < 4) ? ~op : op;
         zero   = (ph < 4) ? ~z : z;
         sb_q.push_back('{ph: 3'(ph), st: exp[ph]});
      end
   endtask

   task automatic run_instr(input opcode_t op, input logic z, input vec_t exp);
      run_phases(op, z, exp, 8);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_now(input string name);
      rst_ = 1'b0;
      #1;
      check(name, {phase, strobes()}, {3'd0, 7'b0000000});
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst_ = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      opcode = ADD;
      repeat (2) @(posedge clk);
      #1;
      check("reset state", {phase, strobes()}, {3'd0, 7'b0000000});
      rst_ = 1'b1;

      // Full ADD cycle; the following LDA starting in phase 0 shows the wrap.
      run_instr(ADD, 1'b0, ALU_V);
      run_instr(LDA, 1'b1, ALU_V);
      run_instr(SKZ, 1'b1, SKZ1_V);
      run_instr(SKZ, 1'b0, SKZ0_V);
      run_instr(JMP, 1'b0, JMP_V);
      run_instr(STO, 1'b1, STO_V);
      run_instr(XOR, 1'b1, ALU_V);

      // Asynchronous reset mid-clock while fetch strobes are active.
      run_phases(AND, 1'b0, ALU_V, 4);
      @(negedge clk);
      #2;
      reset_now("mid-clock reset");
      release_reset();

      // Reset during ALU_OP of an LDA: load_ac must drop at once, no STORE follows.
      run_phases(LDA, 1'b0, ALU_V, 7);
      @(negedge clk);
      #1;
      reset_now("reset in ALU_OP");
      release_reset();
      run_instr(ADD, 1'b0, ALU_V);

      // Halt: freeze in OP_FETCH, insensitive to opcode/zero.
      run_phases(HLT, 1'b0, HLT_V, 5);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         opcode = 3'(i);
         zero   = i[0];
         sb_q.push_back('{ph: 3'd5, st: HALTED});
      end
      @(negedge clk);
      #1;
      reset_now("reset clears halt");
      release_reset();
      run_instr(JMP, 1'b1, JMP_V);

      @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
